memory_checker: RTL

- Memory-mapped result checker for CPU test benches; successor to the single-array tester.
- Decodes a window of `array_size` words at `base_addr` on the CPU bus and stores CPU writes in a shadow array.
- Compares the shadow array against a parametrised expected image and reports pass/fail through flags and a readable status word.
- Read data is zero when the block is not addressed, so it can be OR-ed onto a shared `data_in` bus next to ROMs and RAMs.

---
 rtl/memory_checker_pkg.sv | 38 +++
 rtl/memory_checker_decode.sv | 38 +++
 rtl/memory_checker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_checker_pkg.sv
// -----------------------------------------------------------------------------
// memory_checker_pkg
//
// Shared definitions for the memory-mapped result checker:
//   - state_t        : checker state encoding (IDLE/FILLING/COMPLETE/FAILED)
//   - *_BIT/STATE_LSB: bit positions inside the readable status word
//   - INDEX_W        : width of element indices / error_index
//   - pack_status()  : builds the 4-bit status nibble from state and flags
// -----------------------------------------------------------------------------
package memory_checker_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILLING  = 2'd1,
        COMPLETE = 2'd2,
        FAILED   = 2'd3
    } state_t;

    localparam int CONTENT_OK_BIT = 0;
    localparam int ERROR_BIT      = 1;
    localparam int STATE_LSB      = 2;
    localparam int STATUS_W       = 4;
    localparam int INDEX_W        = 8;

    function automatic logic [STATUS_W-1:0] pack_status(
        input state_t st,
        input logic   err,
        input logic   ok
    );
        logic [STATUS_W-1:0] r;
        r                   = '0;
        r[CONTENT_OK_BIT]   = ok;
        r[ERROR_BIT]        = err;
        r[STATE_LSB +: 2]   = st;
        return r;
    endfunction

endpackage

// File: rtl/memory_checker_decode.sv
// -----------------------------------------------------------------------------
// memory_checker_decode
//
// Combinational address decode for a window of array_size words starting at
// base_addr, plus one status word directly above the window.
//
// Ports:
//   addr        in  addr_size  bus address
//   hit_elem    out 1          addr lies inside the element window
//   hit_status  out 1          addr equals base_addr + array_size
//   index       out 8          addr - base_addr (meaningful only when hit_elem)
// -----------------------------------------------------------------------------
module memory_checker_decode #(
    parameter int unsigned           addr_size  = 16,
    parameter logic [addr_size-1:0]  base_addr  = '0,
    parameter int unsigned           array_size = 4
) (
    input  logic [addr_size-1:0] addr,
    output logic                 hit_elem,
    output logic                 hit_status,
    output logic [7:0]           index
);

    // One extra bit so the upper bound of the window never wraps in the compare.
    localparam int unsigned    EXT_W  = addr_size + 1;
    localparam logic [EXT_W-1:0] WIN_LO = {1'b0, base_addr};
    localparam logic [EXT_W-1:0] WIN_HI = WIN_LO + EXT_W'(array_size);

    logic [EXT_W-1:0] addr_ext;

    assign addr_ext   = {1'b0, addr};
    assign hit_elem   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign hit_status = (addr_ext == WIN_HI);

    // Indices are below 256, so the low byte of the difference is exact.
    assign index      = 8'(addr) - 8'(base_addr);

endmodule

// File: rtl/memory_checker.sv
// -----------------------------------------------------------------------------
// memory_checker
//
// Memory-mapped result checker. CPU writes into the decoded window are kept in
// a shadow array and compared against the expected image array_content
// (elements excluded by care_mask are stored but never compared).
//
// Optional build macro: MEMORY_CHECKER_ORDER_EN
//   When defined, cared elements must be written once each in ascending index
//   order; the first violation latches FAILED, error=1 and error_index.
//
// Ports:
//   clk          in  1          system clock (rising edge)
//   reset        in  1          asynchronous active-low reset
//   addr         in  addr_size  CPU bus address
//   data_in      in  word_size  CPU write data
//   write_en     in  1          CPU write strobe
//   data_out     out word_size  registered read data, zero when not addressed
//   content_ok   out 1          all cared elements written and matching
//   error        out 1          sticky ordering failure
//   error_index  out 8          index of first failing write
//
// Status word (address base_addr+array_size), bits [3:0]:
//   {state[1:0], error, content_ok}, upper bits zero.
// -----------------------------------------------------------------------------
module memory_checker
    import memory_checker_pkg::*;
#(
    parameter int unsigned                      addr_size     = 16,
    parameter logic [addr_size-1:0]             base_addr     = '0,
    parameter int unsigned                      word_size     = 16,
    parameter int unsigned                      array_size    = 4,
    parameter logic [array_size*word_size-1:0]  array_content = '0,
    parameter logic [array_size-1:0]            care_mask     = {array_size{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addr_size-1:0] addr,
    input  logic [word_size-1:0] data_in,
    input  logic                 write_en,
    output logic [word_size-1:0] data_out,
    output logic                 content_ok,
    output logic                 error,
    output logic [7:0]           error_index
);

    logic                  hit_elem;
    logic                  hit_status;
    logic [7:0]            index;

    logic [word_size-1:0]  shadow_reg  [array_size];
    logic [word_size-1:0]  shadow_next [array_size];
    logic [array_size-1:0] written_reg;
    logic [array_size-1:0] written_next;
    logic [array_size-1:0] we_vec;
    logic [array_size-1:0] match_next;
    logic                  all_ok_next;

    state_t                state_reg;
    state_t                state_next;

    logic [word_size-1:0]  elem_rd;
    logic [word_size-1:0]  data_out_reg;
    logic [word_size-1:0]  data_out_next;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    memory_checker_decode #(
        .addr_size  (addr_size),
        .base_addr  (base_addr),
        .array_size (array_size)
    ) u_decode (
        .addr       (addr),
        .hit_elem   (hit_elem),
        .hit_status (hit_status),
        .index      (index)
    );

    // ------------------------------------------------------------------
    // Per-element write enables and next-cycle contents. The state machine
    // looks at the post-write view so content_ok rises right after the
    // completing write instead of one cycle later.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < array_size; gi++) begin : g_elem
        assign we_vec[gi]       = write_en & hit_elem & (index == 8'(gi));
        assign shadow_next[gi]  = we_vec[gi] ? data_in : shadow_reg[gi];
        assign written_next[gi] = written_reg[gi] | we_vec[gi];
        assign match_next[gi]   = ~care_mask[gi]
                                | (written_next[gi]
                                   & (shadow_next[gi] == array_content[gi*word_size +: word_size]));
    end

    assign all_ok_next = &match_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(array_size); i++) begin
                shadow_reg[i] <= '0;
            end
            written_reg <= '0;
        end else begin
            shadow_reg  <= shadow_next;
            written_reg <= written_next;
        end
    end

`ifdef MEMORY_CHECKER_ORDER_EN
    // ------------------------------------------------------------------
    // Ordering check: a cared write is legal only if that element has not
    // been written and every cared element below it already has.
    // ------------------------------------------------------------------
    logic [array_size-1:0] lower_done;
    logic [array_size-1:0] viol_vec;
    logic                  order_violation;
    logic [7:0]            error_index_reg;

    for (genvar gi = 0; gi < array_size; gi++) begin : g_order
        if (gi == 0) begin : g_first
            assign lower_done[gi] = 1'b1;
        end else begin : g_rest
            assign lower_done[gi] = lower_done[gi-1]
                                  & (written_reg[gi-1] | ~care_mask[gi-1]);
        end
        assign viol_vec[gi] = we_vec[gi] & care_mask[gi]
                            & (written_reg[gi] | ~lower_done[gi]);
    end

    assign order_violation = |viol_vec;

    // Only the first violation is recorded; FAILED is terminal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_index_reg <= '0;
        end else if (state_reg != FAILED && order_violation) begin
            error_index_reg <= index;
        end
    end

    assign error_index = error_index_reg;
`else
    assign error_index = '0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // With an empty care mask the first write already completes.
                if (|we_vec) begin
                    state_next = all_ok_next ? COMPLETE : FILLING;
                end
            end
            FILLING, COMPLETE: begin
                state_next = all_ok_next ? COMPLETE : FILLING;
            end
            FAILED: begin
                state_next = FAILED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef MEMORY_CHECKER_ORDER_EN
        if (state_reg != FAILED && order_violation) begin
            state_next = FAILED;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        content_ok = (state_reg == COMPLETE);
`ifdef MEMORY_CHECKER_ORDER_EN
        error      = (state_reg == FAILED);
`else
        error      = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Read path: registered, one cycle latency, zero when not addressed so
    // the output can be OR-ed onto a shared read bus. Reads see the shadow
    // contents before any same-cycle write.
    // ------------------------------------------------------------------
    always_comb begin
        elem_rd = '0;
        for (int i = 0; i < int'(array_size); i++) begin
            if (index == 8'(i)) begin
                elem_rd = shadow_reg[i];
            end
        end
    end

    always_comb begin
        data_out_next = '0;
        if (hit_elem) begin
            data_out_next = elem_rd;
        end else if (hit_status) begin
            data_out_next[STATUS_W-1:0] = pack_status(state_reg, error, content_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg <= '0;
        end else begin
            data_out_reg <= data_out_next;
        end
    end

    assign data_out = data_out_reg;

endmodule
